hood_mode_controller: RTL
=========================

// Module: hood_mode_controller
// PURPOSE
//  Main range-hood mode FSM: sequences OFF/STANDBY/MODE_SELECT/FIRST/SECOND/THIRD_LEVEL/SELF_CLEAN
//  from debounced single-cycle button pulses and a 1 Hz strobe. Drives the 3-bit state bus consumed
//  by mode_indicator, plus fan level and a seconds countdown for the display path.
// PARAMETERS
//  CNT_W          8    countdown register width
//  THIRD_SECONDS  60   THIRD_LEVEL run time before auto-drop to SECOND_LEVEL (<2**CNT_W)
//  EXIT_SECONDS   60   delay from menu press in THIRD_LEVEL to STANDBY (<2**CNT_W)
//  CLEAN_SECONDS  180  SELF_CLEAN run time before return to STANDBY (<2**CNT_W)
// PORTS
//  clk         in   1      system clock
//  rst         in   1      synchronous reset, active-high
//  tick_1s     in   1      one-cycle strobe, once per second
//  power_btn   in   1      one-cycle pulse, power toggle
//  menu_btn    in   1      one-cycle pulse, menu/back
//  lvl1_btn    in   1      one-cycle pulse, select level 1
//  lvl2_btn    in   1      one-cycle pulse, select level 2
//  lvl3_btn    in   1      one-cycle pulse, select level 3
//  clean_btn   in   1      one-cycle pulse, select self-clean
//  state       out  3      OFF=000 STANDBY=001 MODE_SELECT=010 FIRST=011 SECOND=100 THIRD=101 CLEAN=110
//  fan_level   out  2      0 off, 1/2/3 = FIRST/SECOND/THIRD (SELF_CLEAN drives 3)
//  countdown   out  CNT_W  seconds remaining in timed phase, else 0
//  third_used  out  1      THIRD_LEVEL entered since last power-on
//  clean_done  out  1      one-cycle pulse when SELF_CLEAN completes
// BEHAVIOUR
//  - rst (sync, high): state=OFF, fan_level=0, countdown=0, third_used=0, clean_done=0, exiting=0.
//  - All outputs registered; state change visible one clk after the sampled pulse.
//  - Per-cycle priority when several pulses coincide: power > clean > lvl3 > lvl2 > lvl1 > menu; lower ignored.
//  - OFF: power -> STANDBY; all other inputs ignored.
//  - power_btn in any non-OFF state -> OFF; clears countdown, exiting, third_used.
//  - STANDBY: menu -> MODE_SELECT.
//  - MODE_SELECT: lvl1->FIRST, lvl2->SECOND, lvl3->THIRD only if third_used=0 (else ignored, stay),
//    clean->SELF_CLEAN, menu->STANDBY.
//  - FIRST/SECOND: lvl1/lvl2 switch directly between them; menu -> STANDBY; lvl3/clean ignored.
//  - THIRD entry: countdown<=THIRD_SECONDS, third_used<=1, exiting<=0.
//    tick while not exiting: decrement; tick at countdown==1 -> SECOND_LEVEL, countdown=0.
//    menu while not exiting: exiting<=1, countdown<=EXIT_SECONDS, fan stays 3;
//    tick at countdown==1 while exiting -> STANDBY. Further menu/lvl presses ignored in THIRD.
//  - SELF_CLEAN entry: countdown<=CLEAN_SECONDS; tick decrements; tick at countdown==1 -> STANDBY,
//    clean_done=1 for exactly that cycle. menu/lvl ignored (only power aborts; no clean_done on abort).
//  - Load wins over decrement: tick in the same cycle as a load is ignored. Countdown never wraps below 0.
//  - fan_level derived registered from next state; 0 in OFF/STANDBY/MODE_SELECT.
//  - Unused encoding 111 -> OFF next cycle (recovery).
// STRUCTURE
//  - Shared package/header hood_pkg: state encodings (identical to mode_indicator's), fan-level codes.
//  - One sub-module natural: hood_sec_timer (load/decrement/expire, CNT_W wide, load-priority).
//  - FSM + third_used/exiting flags in this module.
// TESTING
//  1 rst; power; menu; lvl2 -> state 000->001->010->100, fan_level=2; menu -> 001, fan 0.
//  2 MODE_SELECT, lvl3 -> state 101, countdown=60, third_used=1; 60 ticks -> state 100, countdown 0;
//    menu, menu, lvl3 -> stays 010 (third_used blocks).
//  3 THIRD, 10 ticks (countdown 50), menu -> countdown=60, fan 3; 60 ticks -> state 001.
//  4 clean -> 110, countdown 180; 180 ticks -> 001, clean_done high exactly 1 cycle; power mid-clean -> 000, no pulse.
//  5 lvl3 and clean same cycle in MODE_SELECT -> 110; tick same cycle as entry -> countdown 180 (not 179).
//  6 rst asserted mid-THIRD (countdown 30) -> next clk all outputs at reset values; power then lvl3 allowed again.

Source files
------------

// File: rtl/hood_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hood_pkg
//  Description : Shared definitions for the range-hood mode path. Holds the
//                3-bit mode encoding (common with mode_indicator), the fan
//                level codes, the decoded-button type and small helpers.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package hood_pkg;

    // Mode encoding driven onto the state bus. 3'b111 is never entered
    // intentionally; the controller recovers from it to OFF.
    typedef enum logic [2:0] {
        ST_OFF         = 3'b000,
        ST_STANDBY     = 3'b001,
        ST_MODE_SELECT = 3'b010,
        ST_FIRST       = 3'b011,
        ST_SECOND      = 3'b100,
        ST_THIRD       = 3'b101,
        ST_CLEAN       = 3'b110,
        ST_ILLEGAL     = 3'b111
    } hood_state_t;

    localparam logic [1:0] C_FAN_OFF = 2'd0;
    localparam logic [1:0] C_FAN_L1  = 2'd1;
    localparam logic [1:0] C_FAN_L2  = 2'd2;
    localparam logic [1:0] C_FAN_L3  = 2'd3;

    // The single button that is acted on in a cycle after priority resolution.
    typedef enum logic [2:0] {
        BTN_NONE  = 3'd0,
        BTN_POWER = 3'd1,
        BTN_CLEAN = 3'd2,
        BTN_LVL3  = 3'd3,
        BTN_LVL2  = 3'd4,
        BTN_LVL1  = 3'd5,
        BTN_MENU  = 3'd6
    } btn_t;

    // Coincident pulses: only the highest-priority one survives, the rest
    // are dropped even if the winner itself turns out to be ignored.
    function automatic btn_t pick_btn(
        input logic power,
        input logic clean,
        input logic lvl3,
        input logic lvl2,
        input logic lvl1,
        input logic menu
    );
        if (power)      return BTN_POWER;
        else if (clean) return BTN_CLEAN;
        else if (lvl3)  return BTN_LVL3;
        else if (lvl2)  return BTN_LVL2;
        else if (lvl1)  return BTN_LVL1;
        else if (menu)  return BTN_MENU;
        else            return BTN_NONE;
    endfunction

    // Fan level implied by a mode; SELF_CLEAN runs the fan at full speed.
    function automatic logic [1:0] fan_for(input hood_state_t s);
        case (s)
            ST_FIRST:  return C_FAN_L1;
            ST_SECOND: return C_FAN_L2;
            ST_THIRD:  return C_FAN_L3;
            ST_CLEAN:  return C_FAN_L3;
            default:   return C_FAN_OFF;
        endcase
    endfunction

endpackage : hood_pkg
`default_nettype wire

// File: rtl/hood_sec_timer.sv
`default_nettype none
// ============================================================================
//  Module      : hood_sec_timer
//  Description : Seconds countdown register. Load has priority over clear,
//                clear over decrement. Decrements only on tick and saturates
//                at zero. 'expire' flags a tick arriving while the count is
//                1; the owner decides whether a simultaneous load overrides.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                load/load_val - load a new count (wins over tick)
//                clear         - force count to zero
//                tick          - 1 Hz strobe
//                count         - current count (registered)
//                expire        - tick seen with count == 1
//  Revision    : 1.0 - initial release
// ============================================================================
module hood_sec_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             clear,
    input  logic             tick,
    output logic [CNT_W-1:0] count,
    output logic             expire
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (clear) begin
            r_count <= '0;
        end else if (tick && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign count  = r_count;
    assign expire = tick && (r_count == CNT_W'(1));

endmodule : hood_sec_timer
`default_nettype wire

// File: rtl/hood_mode_controller.sv
`default_nettype none
// ============================================================================
//  Module      : hood_mode_controller
//  Description : Range-hood mode FSM. Sequences OFF / STANDBY / MODE_SELECT /
//                FIRST / SECOND / THIRD_LEVEL / SELF_CLEAN from one-cycle
//                button pulses and a 1 Hz strobe; drives mode bus, fan level,
//                seconds countdown, third-level usage flag and a clean-done
//                pulse. All outputs are registered.
//  Ports       : clk, rst         - clock, synchronous active-high reset
//                tick_1s          - one-cycle strobe per second
//                power_btn .. clean_btn - one-cycle button pulses
//                state[2:0]       - current mode
//                fan_level[1:0]   - 0 off, 1..3 fan speed
//                countdown[CNT_W] - seconds left in timed phase, else 0
//                third_used       - THIRD entered since last power-on
//                clean_done       - one-cycle pulse on SELF_CLEAN completion
//  Revision    : 1.0 - initial release
// ============================================================================
module hood_mode_controller
    import hood_pkg::*;
#(
    parameter int CNT_W         = 8,
    parameter int THIRD_SECONDS = 60,
    parameter int EXIT_SECONDS  = 60,
    parameter int CLEAN_SECONDS = 180
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_1s,
    input  logic             power_btn,
    input  logic             menu_btn,
    input  logic             lvl1_btn,
    input  logic             lvl2_btn,
    input  logic             lvl3_btn,
    input  logic             clean_btn,
    output logic [2:0]       state,
    output logic [1:0]       fan_level,
    output logic [CNT_W-1:0] countdown,
    output logic             third_used,
    output logic             clean_done
);

    hood_state_t      r_state;
    hood_state_t      w_next;
    logic [1:0]       r_fan;
    logic             r_third_used;
    logic             r_exiting;
    logic             r_clean_done;

    btn_t             w_btn;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_clear;
    logic             w_set_exit;
    logic             w_expire;
    logic             w_enter_third;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = '0;
        w_set_exit = 1'b0;
        w_btn      = pick_btn(power_btn, clean_btn, lvl3_btn,
                              lvl2_btn, lvl1_btn, menu_btn);

        if (r_state == ST_OFF) begin
            if (w_btn == BTN_POWER) begin
                w_next = ST_STANDBY;
            end
        end else if (w_btn == BTN_POWER) begin
            w_next = ST_OFF;
        end else begin
            case (r_state)
                ST_STANDBY: begin
                    if (w_btn == BTN_MENU) begin
                        w_next = ST_MODE_SELECT;
                    end
                end
                ST_MODE_SELECT: begin
                    case (w_btn)
                        BTN_LVL1: w_next = ST_FIRST;
                        BTN_LVL2: w_next = ST_SECOND;
                        BTN_LVL3: begin
                            // Third level is a one-shot per power cycle.
                            if (!r_third_used) begin
                                w_next     = ST_THIRD;
                                w_load     = 1'b1;
                                w_load_val = CNT_W'(THIRD_SECONDS);
                            end
                        end
                        BTN_CLEAN: begin
                            w_next     = ST_CLEAN;
                            w_load     = 1'b1;
                            w_load_val = CNT_W'(CLEAN_SECONDS);
                        end
                        BTN_MENU: w_next = ST_STANDBY;
                        default:  w_next = r_state;
                    endcase
                end
                ST_FIRST, ST_SECOND: begin
                    case (w_btn)
                        BTN_LVL1: w_next = ST_FIRST;
                        BTN_LVL2: w_next = ST_SECOND;
                        BTN_MENU: w_next = ST_STANDBY;
                        default:  w_next = r_state;
                    endcase
                end
                ST_THIRD: begin
                    // A menu press restarts the timer as an exit delay; the
                    // reload shadows any tick in the same cycle, so expiry
                    // is only considered when no reload happens.
                    if ((w_btn == BTN_MENU) && !r_exiting) begin
                        w_load     = 1'b1;
                        w_load_val = CNT_W'(EXIT_SECONDS);
                        w_set_exit = 1'b1;
                    end else if (w_expire) begin
                        w_next = r_exiting ? ST_STANDBY : ST_SECOND;
                    end
                end
                ST_CLEAN: begin
                    if (w_expire) begin
                        w_next = ST_STANDBY;
                    end
                end
                default: begin
                    w_next = ST_OFF;
                end
            endcase
        end
    end

    // Countdown is only meaningful while in a timed phase.
    assign w_clear       = (w_next != ST_THIRD) && (w_next != ST_CLEAN);
    assign w_enter_third = (w_next == ST_THIRD) && (r_state != ST_THIRD);

    hood_sec_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val (w_load_val),
        .clear    (w_clear),
        .tick     (tick_1s),
        .count    (countdown),
        .expire   (w_expire)
    );

    // ------------------------------------------------------------------
    // State register and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_OFF;
            r_fan        <= C_FAN_OFF;
            r_third_used <= 1'b0;
            r_exiting    <= 1'b0;
            r_clean_done <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_fan        <= fan_for(w_next);
            r_clean_done <= (r_state == ST_CLEAN) && (w_next == ST_STANDBY);

            if (w_next == ST_OFF) begin
                r_third_used <= 1'b0;
            end else if (w_enter_third) begin
                r_third_used <= 1'b1;
            end

            if ((w_next != ST_THIRD) || w_enter_third) begin
                r_exiting <= 1'b0;
            end else if (w_set_exit) begin
                r_exiting <= 1'b1;
            end
        end
    end

    assign state      = r_state;
    assign fan_level  = r_fan;
    assign third_used = r_third_used;
    assign clean_done = r_clean_done;

endmodule : hood_mode_controller
`default_nettype wire
